// File: rtl/csa_resolver.sv
// Digit-serial carry-propagate stage: resolves a carry-save pair (u, v) into a
// binary sum, DIGIT bits per cycle through one registered carry.
module csa_resolver #(
  parameter int W     = 8,
  parameter int DIGIT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   u,
  input  logic [W:1]     v,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   sum,
  output logic [1:0]     dbg_state
);

  localparam int P  = DIGIT * ((W + 2 + DIGIT - 1) / DIGIT);
  localparam int N  = P / DIGIT;
  localparam int CW = $clog2(N + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_ready depends on state only, out_valid/sum are registered.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [P-1:0]    a_q;
  logic [P-1:0]    b_q;
  logic [P-1:0]    res_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;
  logic [W+1:0]    sum_q;

  logic [DIGIT:0]  dig_d;
  logic [P-1:0]    res_d;
  logic            last_d;

  // Operands shift right each digit, so the active digit is always at bit 0;
  // result digits enter at the top and reach their final place after N steps.
  assign dig_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};
  assign res_d  = (res_q >> DIGIT) | (P'(dig_d[DIGIT-1:0]) << (P - DIGIT));
  assign last_d = (cnt_q == CW'(N - 1));

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= P'(u);
            b_q     <= P'({v, 1'b0});
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= dig_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            // Final carry-out is always zero since P >= W+2.
            sum_q       <= res_d[W+1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
